dma_copy_engine: RTL
====================

Name: dma_copy_engine

Overview:
- Memory-mapped peripheral on the openMSP430 peripheral bus. It is the DMA master that drives the core's DMA port (dma_addr/dma_en/dma_we/dma_din, answered by dma_ready/dma_dout/dma_resp).
- Software programs source, destination and word count, then starts the transfer.
- The engine copies words one at a time: read, then write. It reports completion or an error through a status register and an interrupt.

Parameters:
- BASE_ADDR, 15'h0090, byte base address of the register block; aligned to 2^DEC_WD.
- DEC_WD, 3, address decode width (4 word registers).
- PRIO, 1'b0, value driven on dma_priority.

Ports:
- mclk  in  1  main system clock; all state changes on its rising edge.
- puc_rst_n  in  1  synchronous, active-low reset.
- per_addr  in  14  peripheral word address.
- per_din  in  16  peripheral write data.
- per_en  in  1  peripheral enable.
- per_we  in  2  byte write enables ([0] low byte, [1] high byte).
- per_dout  out  16  register read data; 0 when not selected.
- irq  out  1  interrupt = CTRL.IE & (CTRL.DONE | CTRL.ERR).
- dma_addr  out  15  DMA word address.
- dma_en  out  1  DMA access request.
- dma_we  out  2  00 = read, 11 = write.
- dma_din  out  16  DMA write data.
- dma_priority  out  1  tied to PRIO.
- dma_wkup  out  1  constant 0.
- dma_ready  in  1  access accepted this cycle when dma_en=1.
- dma_dout  in  16  read data, valid the cycle after read acceptance.
- dma_resp  in  1  error flag, qualified with acceptance.

Behaviour:
- Decode:
  - reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]).
  - Offsets: CTRL 0x0, SRC 0x2, DST 0x4, CNT 0x6.
  - Reads are combinational when ~|per_we.
  - Writes honour per_we byte lanes.
- CTRL bits:
  - [0] START: write 1 starts; reads back BUSY.
  - [1] DONE: sticky; write 1 clears.
  - [2] ERR: sticky; write 1 clears.
  - [3] IE: read/write.
  - [4] ABORT: write-only; reads 0.
  - [15:5] read 0.
- SRC/DST are byte addresses; bit 0 is ignored and reads 0. CNT is a 16-bit word count.
- While BUSY:
  - Writes to SRC/DST/CNT are ignored.
  - START=1 is ignored.
  - DONE/ERR write-1-clear still works.
- SRC/DST/CNT are working registers and show live progress.
- Reset (puc_rst_n=0 at an edge):
  - State IDLE; SRC=DST=CNT=0; CTRL=0.
  - dma_en=0, dma_we=00, dma_addr=0, dma_din=0.
  - Reset overrides any pending access or register write.
- FSM states: IDLE, RD, RDW, WR.
  - IDLE: write of START=1 with CNT≠0 → RD next cycle. With CNT=0 → stay IDLE and set DONE next cycle; no DMA access.
  - RD: dma_en=1, dma_we=00, dma_addr=SRC[15:1]; outputs held stable until dma_ready. On acceptance:
    - dma_resp=1 → IDLE, set ERR, counters unchanged.
    - otherwise → RDW; SRC += 2 (mod 2^16).
  - RDW: dma_en=0; latch dma_dout into the data buffer → WR.
  - WR: dma_en=1, dma_we=11, dma_addr=DST[15:1], dma_din=buffer; held stable until dma_ready. On acceptance:
    - dma_resp=1 → IDLE, set ERR.
    - else DST += 2 and CNT -= 1; if the new CNT=0 → IDLE and set DONE, else → RD.
- Throughput: 3 cycles per word with dma_ready held high. The first dma_en is asserted the cycle after the START write.
- Address wrap: 0xFFFE + 2 → 0x0000; no error.
- ABORT=1 while BUSY:
  - Effective at the next edge; → IDLE, dma_en=0, ERR set.
  - Has priority over a simultaneous acceptance: that access's counter update is discarded.
  - ABORT while IDLE has no effect.
- Simultaneous DONE set and software DONE write-1-clear in the same cycle: the set wins.
- irq is registered from the flags, combinational only in the AND.

Test Plan:
- Basic copy:
  - Stimulus: SRC=0x0200, DST=0x0300, CNT=3, START, dma_ready=1, memory words 0xA1A1/0xB2B2/0xC3C3.
  - Required: three read/write pairs at word addresses 0x100/0x180, 0x101/0x181, 0x102/0x182; DONE after 9 cycles; CNT=0, SRC=0x0206, DST=0x0306.
- Backpressure:
  - Stimulus: dma_ready low for 4 cycles during each WR.
  - Required: dma_addr/dma_din/dma_we held stable; data correct; 7 cycles per word.
- Error:
  - Stimulus: dma_resp=1 on the second read acceptance, IE=1.
  - Required: ERR=1, DONE=0, irq=1, CNT=2, second word not written; writing CTRL=0x0004 clears ERR and irq.
- Zero count and wrap:
  - Stimulus: CNT=0 START.
  - Required: DONE next cycle, no dma_en.
  - Stimulus: SRC=0xFFFE, CNT=2.
  - Required: reads at word 0x7FFF then 0x0000.
- Abort and reset:
  - Stimulus: ABORT during a stalled WR.
  - Required: dma_en drops next cycle; ERR=1; CNT unchanged.
  - Stimulus: puc_rst_n=0 mid-transfer.
  - Required: all registers 0, dma_en=0 at the next edge.
- Register access:
  - Stimulus: byte write per_we=01 of 0x1234 to SRC.
  - Required: SRC=0x0034 from 0.
  - Stimulus: writes to SRC while BUSY.
  - Required: ignored.
  - Stimulus: read at an unmapped address.
  - Required: per_dout=0.

Source files
------------

// File: rtl/dma_copy_engine.sv
// Peripheral-bus DMA copy engine: word-by-word read/write copy
// from SRC to DST for CNT words, with done/error flags and irq.
module dma_copy_engine #(
   parameter logic [14:0] BASE_ADDR = 15'h0090,
   parameter int          DEC_WD    = 3,
   parameter logic        PRIO      = 1'b0
) (
   input  logic        mclk,
   input  logic        puc_rst_n,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout,
   output logic        irq,
   output logic [14:0] dma_addr,
   output logic        dma_en,
   output logic [1:0]  dma_we,
   output logic [15:0] dma_din,
   output logic        dma_priority,
   output logic        dma_wkup,
   input  logic        dma_ready,
   input  logic [15:0] dma_dout,
   input  logic        dma_resp
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_RDW  = 2'd2;
   localparam logic [1:0] S_WR   = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [15:0]       src;
   logic [15:0]       dst;
   logic [15:0]       cnt;
   logic [15:0]       data_buf;
   logic              done;
   logic              err;
   logic              ie;

   logic              reg_sel;
   logic              reg_wr;
   logic [DEC_WD-2:0] reg_idx;
   logic [15:0]       wmask;
   logic [15:0]       src_wval;
   logic [15:0]       dst_wval;
   logic [15:0]       cnt_wval;
   logic              wr_ctrl;
   logic              wr_src;
   logic              wr_dst;
   logic              wr_cnt;
   logic              start;
   logic              abort;
   logic              clr_done;
   logic              clr_err;
   logic              busy;

   logic              set_done;
   logic              set_err;
   logic              src_inc;
   logic              wr_step;
   logic              buf_ld;

   // Register decode and byte-lane write merge
   always_comb begin
      reg_sel  = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
      reg_wr   = reg_sel & (|per_we);
      reg_idx  = per_addr[DEC_WD-2:0];
      wmask    = {{8{per_we[1]}}, {8{per_we[0]}}};
      src_wval = (per_din & wmask) | (src & ~wmask);
      dst_wval = (per_din & wmask) | (dst & ~wmask);
      cnt_wval = (per_din & wmask) | (cnt & ~wmask);
      busy     = (state != S_IDLE);
      wr_ctrl  = reg_wr & (int'(reg_idx) == 0) & per_we[0];
      wr_src   = reg_wr & (int'(reg_idx) == 1) & ~busy;
      wr_dst   = reg_wr & (int'(reg_idx) == 2) & ~busy;
      wr_cnt   = reg_wr & (int'(reg_idx) == 3) & ~busy;
      start    = wr_ctrl & per_din[0];
      abort    = wr_ctrl & per_din[4];
      clr_done = wr_ctrl & per_din[1];
      clr_err  = wr_ctrl & per_din[2];
   end

   always_comb begin
      per_dout = 16'h0000;
      if (reg_sel && !(|per_we)) begin
         case (int'(reg_idx))
            0:       per_dout = {11'h000, 1'b0, ie, err, done, busy};
            1:       per_dout = src;
            2:       per_dout = dst;
            3:       per_dout = cnt;
            default: per_dout = 16'h0000;
         endcase
      end
   end

   // Transfer sequencing; abort outranks a same-cycle acceptance
   always_comb begin
      state_nxt = state;
      set_done  = 1'b0;
      set_err   = 1'b0;
      src_inc   = 1'b0;
      wr_step   = 1'b0;
      buf_ld    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (cnt != 16'h0000) state_nxt = S_RD;
               else                 set_done  = 1'b1;
            end
         end
         S_RD: begin
            if (abort) begin
               state_nxt = S_IDLE;
               set_err   = 1'b1;
            end else if (dma_ready) begin
               if (dma_resp) begin
                  state_nxt = S_IDLE;
                  set_err   = 1'b1;
               end else begin
                  state_nxt = S_RDW;
                  src_inc   = 1'b1;
               end
            end
         end
         S_RDW: begin
            if (abort) begin
               state_nxt = S_IDLE;
               set_err   = 1'b1;
            end else begin
               state_nxt = S_WR;
               buf_ld    = 1'b1;
            end
         end
         S_WR: begin
            if (abort) begin
               state_nxt = S_IDLE;
               set_err   = 1'b1;
            end else if (dma_ready) begin
               if (dma_resp) begin
                  state_nxt = S_IDLE;
                  set_err   = 1'b1;
               end else begin
                  wr_step = 1'b1;
                  if (cnt == 16'h0001) begin
                     state_nxt = S_IDLE;
                     set_done  = 1'b1;
                  end else begin
                     state_nxt = S_RD;
                  end
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (!puc_rst_n) begin
         state    <= S_IDLE;
         src      <= 16'h0000;
         dst      <= 16'h0000;
         cnt      <= 16'h0000;
         data_buf <= 16'h0000;
         done     <= 1'b0;
         err      <= 1'b0;
         ie       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wr_ctrl) ie <= per_din[3];
         // a flag set beats a same-cycle write-1-clear
         done <= (done & ~clr_done) | set_done;
         err  <= (err & ~clr_err) | set_err;
         if (buf_ld) data_buf <= dma_dout;
         if (src_inc)     src <= src + 16'd2;
         else if (wr_src) src <= {src_wval[15:1], 1'b0};
         if (wr_step)     dst <= dst + 16'd2;
         else if (wr_dst) dst <= {dst_wval[15:1], 1'b0};
         if (wr_step)     cnt <= cnt - 16'd1;
         else if (wr_cnt) cnt <= cnt_wval;
      end
   end

   always_comb begin
      dma_en   = (state == S_RD) | (state == S_WR);
      dma_we   = {2{state == S_WR}};
      dma_addr = 15'h0000;
      dma_din  = 16'h0000;
      if (state == S_RD) dma_addr = src[15:1];
      if (state == S_WR) begin
         dma_addr = dst[15:1];
         dma_din  = data_buf;
      end
   end

   assign irq          = ie & (done | err);
   assign dma_priority = PRIO;
   assign dma_wkup     = 1'b0;

endmodule
